// File: rtl/signal_receiver.sv
// signal_receiver: captures one frame of strobed sample bytes into a
// DEPTH-entry buffer, then holds it for the consumer until acknowledged.
// Frames close either when the buffer fills or when the sender raises
// endFlg after at least one byte. Bytes arriving while a frame is held
// are dropped and reported through a sticky overflow flag.
module signal_receiver #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             inputQuantSig,
    input  logic                         dataRdyFlg,
    input  logic                         endFlg,
    input  logic                         bufAckFlg,
    output logic [DEPTH-1:0][WIDTH-1:0]  inbytes,
    output logic [8:0]                   byteCount,
    output logic                         bufRdyFlg,
    output logic                         shortFlg,
    output logic                         overflowFlg
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_C = 9'(DEPTH);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    state_e                       state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0]  inbytes_q, inbytes_d;
    logic [8:0]                   count_q, count_d;
    logic                         rdy_q, rdy_d;
    logic                         short_q, short_d;
    logic                         ovf_q, ovf_d;
    logic [8:0]                   count_inc_s;
    logic [AW-1:0]                wr_idx_s;

    // Next-state, buffer write and flag logic for the collect/hold FSM.
    always_comb begin
        state_d     = state_q;
        inbytes_d   = inbytes_q;
        count_d     = count_q;
        short_d     = short_q;
        ovf_d       = ovf_q;
        count_inc_s = count_q + 9'd1;
        // While collecting, count_q < DEPTH, so the low bits address the
        // next free slot without wrapping.
        wr_idx_s    = count_q[AW-1:0];

        case (state_q)
            COLLECT: begin
                if (dataRdyFlg) begin
                    // Byte is written before any same-cycle close is applied.
                    inbytes_d[wr_idx_s] = inputQuantSig;
                    count_d             = count_inc_s;
                    if (count_inc_s == DEPTH_C) begin
                        state_d = FULL;
                        short_d = 1'b0;
                    end else if (endFlg) begin
                        state_d = FULL;
                        short_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end else if (endFlg && (count_q != 9'd0)) begin
                    // Count is below DEPTH here, so this frame is short.
                    state_d = FULL;
                    short_d = 1'b1;
                end else begin
                    // Idle sender may hold endFlg high with an empty buffer.
                    state_d = COLLECT;
                end
            end
            FULL: begin
                if (bufAckFlg) begin
                    // Contents stay; only the bookkeeping is cleared.
                    // A strobe in this cycle is simply dropped.
                    state_d = COLLECT;
                    count_d = 9'd0;
                    short_d = 1'b0;
                    ovf_d   = 1'b0;
                end else if (dataRdyFlg) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = 9'd0;
                short_d = 1'b0;
                ovf_d   = 1'b0;
            end
        endcase

        rdy_d = (state_d == FULL);
    end

    // State, buffer and flag registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            inbytes_q <= '0;
            count_q   <= 9'd0;
            rdy_q     <= 1'b0;
            short_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inbytes_q <= inbytes_d;
            count_q   <= count_d;
            rdy_q     <= rdy_d;
            short_q   <= short_d;
            ovf_q     <= ovf_d;
        end
    end

    assign inbytes     = inbytes_q;
    assign byteCount   = count_q;
    assign bufRdyFlg   = rdy_q;
    assign shortFlg    = short_q;
    assign overflowFlg = ovf_q;

endmodule
